// File: rtl/rom_loader.sv
// rom_loader
//
// Program loader for the 16-bank instruction ROM array. It takes a byte
// stream over a valid/ready handshake and assembles big-endian 16-bit words.
// Each word is written to the ROM at consecutive word addresses starting
// from 0. The loader runs after reset or on a host request, before the CPU
// starts fetching.
//
// Optional feature macro: ROM_LOADER_CHECKSUM_EN
//   When defined, a 16-bit modulo-2^16 sum of every written word is kept.
//   Two trailing bytes (high byte first) carry the expected sum. They are
//   compared at the end of the load, and the result is reported on csum_err.
//   When undefined, there is no accumulator, no trailing bytes are taken,
//   and csum_err is tied low.
//
// Parameters:
//   LOAD_WORDS  words written per load, 1..2048
//
// Ports:
//   CLK         clock, rising edge
//   RST_N       asynchronous active-low reset
//   start       one-cycle load request, ignored while busy
//   abort       synchronous cancel of a load in progress
//   byte_in     stream data byte
//   byte_valid  byte_in is valid
//   byte_ready  loader accepts a byte this cycle
//   column_id   ROM word address ([10:7] bank, [6:0] word in bank)
//   wdata       word presented to the ROM write port
//   mode        ROM mode: 2'b01 = write selected bank, 2'b00 = no write
//   busy        a load is in progress
//   done        one-cycle pulse when a load completes
//   csum_err    checksum mismatch flag (always 0 without the checksum option)

module rom_loader #(
    parameter int LOAD_WORDS = 2048
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        start,
    input  logic        abort,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic [10:0] column_id,
    output logic [15:0] wdata,
    output logic [1:0]  mode,
    output logic        busy,
    output logic        done,
    output logic        csum_err
);

    localparam logic [10:0] LAST_ADDR = 11'(LOAD_WORDS - 1);
    localparam logic [1:0]  MODE_IDLE  = 2'b00;
    localparam logic [1:0]  MODE_WRITE = 2'b01;

`ifdef ROM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        IDLE,
        HI,
        LO,
        WRITE,
        DONE,
        CHI,
        CLO
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE,
        HI,
        LO,
        WRITE,
        DONE
    } state_t;
`endif

    state_t state;

    // byte_ready is a registered output. A byte is therefore consumed
    // exactly when the producer's valid coincides with the registered ready.
    logic accept;
    assign accept = byte_valid & byte_ready;

`ifdef ROM_LOADER_CHECKSUM_EN
    logic [15:0] csum_acc;
    logic [7:0]  csum_hi;
    logic        csum_flag;

    assign csum_err = csum_flag;
`else
    assign csum_err = 1'b0;
`endif

    // Single FSM with registered outputs. mode and done default to their
    // inactive values every cycle. They are raised only on the edge that
    // enters WRITE or DONE, so each lasts exactly one cycle. column_id
    // doubles as the word address counter. Because it is only ever
    // incremented from WRITE and only when it is below LAST_ADDR, it can
    // never wrap within a load.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= IDLE;
            column_id  <= '0;
            wdata      <= '0;
            mode       <= MODE_IDLE;
            byte_ready <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef ROM_LOADER_CHECKSUM_EN
            csum_acc   <= '0;
            csum_hi    <= '0;
            csum_flag  <= 1'b0;
`endif
        end else begin
            mode <= MODE_IDLE;
            done <= 1'b0;

            // abort takes priority over any byte accept or write that would
            // otherwise happen on this edge. Words already written remain.
            if (abort && (state != IDLE)) begin
                state      <= IDLE;
                byte_ready <= 1'b0;
                busy       <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
`ifdef ROM_LOADER_CHECKSUM_EN
                        csum_acc <= '0;
`endif
                        // abort in IDLE also suppresses a simultaneous start.
                        if (start && !abort) begin
                            state      <= HI;
                            column_id  <= '0;
                            byte_ready <= 1'b1;
                            busy       <= 1'b1;
`ifdef ROM_LOADER_CHECKSUM_EN
                            // The mismatch flag of the previous load stays
                            // visible in IDLE until a new load is started.
                            csum_flag  <= 1'b0;
`endif
                        end
                    end

                    HI: begin
                        if (accept) begin
                            wdata[15:8] <= byte_in;
                            state       <= LO;
                        end
                    end

                    LO: begin
                        if (accept) begin
                            wdata[7:0] <= byte_in;
                            state      <= WRITE;
                            byte_ready <= 1'b0;
                            mode       <= MODE_WRITE;
                        end
                    end

                    WRITE: begin
`ifdef ROM_LOADER_CHECKSUM_EN
                        csum_acc <= csum_acc + wdata;
`endif
                        if (column_id == LAST_ADDR) begin
`ifdef ROM_LOADER_CHECKSUM_EN
                            state      <= CHI;
                            byte_ready <= 1'b1;
`else
                            state      <= DONE;
                            done       <= 1'b1;
`endif
                        end else begin
                            column_id  <= column_id + 11'd1;
                            state      <= HI;
                            byte_ready <= 1'b1;
                        end
                    end

`ifdef ROM_LOADER_CHECKSUM_EN
                    CHI: begin
                        if (accept) begin
                            csum_hi <= byte_in;
                            state   <= CLO;
                        end
                    end

                    // The trailing bytes go only to the comparator. They
                    // never reach wdata, so they cannot be written to ROM.
                    CLO: begin
                        if (accept) begin
                            state      <= DONE;
                            byte_ready <= 1'b0;
                            done       <= 1'b1;
                            csum_flag  <= (csum_acc != {csum_hi, byte_in});
                        end
                    end
`endif

                    DONE: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end

                    default: begin
                        state      <= IDLE;
                        byte_ready <= 1'b0;
                        busy       <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader
//
// Self-checking bench for rom_loader. It uses two instances: a 4-word
// loader for the table-driven and corner-case loads, and a default
// 2048-word loader for the full-ROM fill. A negedge monitor records every
// ROM write cycle and done pulse. Each load is then compared against an
// expected word list derived from the byte stream.
// Also covers the ROM_LOADER_CHECKSUM_EN option when that macro is defined.

module tb_rom_loader;

    typedef struct {
        logic [10:0] addr;
        logic [15:0] data;
        int          cyc;
    } wr_t;

    typedef struct {
        logic [63:0]       stream;
        bit                gaps;
        logic [0:3][15:0]  exp;
    } vec_t;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        start_a = 1'b0;
    logic        start_b = 1'b0;
    logic        abort = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_in = 8'h00;

    logic        a_byte_ready, b_byte_ready;
    logic [10:0] a_column_id, b_column_id;
    logic [15:0] a_wdata, b_wdata;
    logic [1:0]  a_mode, b_mode;
    logic        a_busy, b_busy;
    logic        a_done, b_done;
    logic        a_csum_err, b_csum_err;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    wr_t         wr_a[$];
    wr_t         wr_b[$];
    int          done_a = 0;
    int          done_b = 0;
    int          done_cyc_a = -1;
    int          done_cyc_b = -1;
    logic        csum_done_a = 1'b0;
    logic        csum_done_b = 1'b0;
    int          illegal_mode = 0;

    logic [7:0]  stim_bytes[$];
    logic [15:0] exp_words[$];
    vec_t        vecs[6];

    rom_loader #(.LOAD_WORDS(4)) dut_a (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .start      (start_a),
        .abort      (abort),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (a_byte_ready),
        .column_id  (a_column_id),
        .wdata      (a_wdata),
        .mode       (a_mode),
        .busy       (a_busy),
        .done       (a_done),
        .csum_err   (a_csum_err)
    );

    rom_loader dut_b (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .start      (start_b),
        .abort      (abort),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (b_byte_ready),
        .column_id  (b_column_id),
        .wdata      (b_wdata),
        .mode       (b_mode),
        .busy       (b_busy),
        .done       (b_done),
        .csum_err   (b_csum_err)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Write/done monitor sampling mid-cycle.
    always @(negedge CLK) begin
        if (a_mode == 2'b01) wr_a.push_back(wr_t'{a_column_id, a_wdata, cyc});
        if (b_mode == 2'b01) wr_b.push_back(wr_t'{b_column_id, b_wdata, cyc});
        if (a_mode[1] || b_mode[1]) illegal_mode++;
        if (a_done) begin
            done_a++;
            done_cyc_a = cyc;
            csum_done_a = a_csum_err;
        end
        if (b_done) begin
            done_b++;
            done_cyc_b = cyc;
            csum_done_b = b_csum_err;
        end
    end

    task automatic check_output(input string name, input logic [63:0] actual,
                                input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic timeout_fail(input string what);
        total++;
        bad++;
        $display("[TB] FAIL %s: timed out waiting on the DUT", what);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    endtask

    task automatic clear_monitor();
        wr_a.delete();
        wr_b.delete();
        done_a = 0;
        done_b = 0;
        done_cyc_a = -1;
        done_cyc_b = -1;
    endtask

    // Reference model: sum of all intended words, modulo 2^16.
    function automatic logic [15:0] model_sum();
        int s = 0;
        foreach (exp_words[i]) s += int'(exp_words[i]);
        return 16'(s % 65536);
    endfunction

    // Reference model: big-endian word i of an 8-byte stream.
    function automatic logic [15:0] model_word(input logic [63:0] stream, input int i);
        longint unsigned s;
        int hi;
        int lo;
        s  = longint'(stream);
        hi = int'((s >> (8 * (7 - 2 * i))) % 256);
        lo = int'((s >> (8 * (6 - 2 * i))) % 256);
        return 16'(hi * 256 + lo);
    endfunction

    // Offer one byte. It is consumed on the next rising edge when both our
    // valid and the DUT's registered ready are high.
    task automatic send_byte(input bit sel, input logic [7:0] b, input bit gaps);
        int   guard;
        logic rdy;
        guard = 0;
        forever begin
            byte_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            byte_in    = byte_valid ? b : 8'($urandom);
            rdy        = sel ? b_byte_ready : a_byte_ready;
            @(negedge CLK);
            if (byte_valid && rdy) break;
            guard++;
            if (guard > 100) timeout_fail("send_byte");
        end
    endtask

    task automatic apply_stimulus(input bit sel, input bit gaps, input logic [15:0] csum);
        int guard;
        $display("[TB] load of %0d bytes on dut_%s, checksum 0x%04h", stim_bytes.size(),
                 sel ? "b" : "a", csum);
        if (sel) start_b = 1'b1;
        else     start_a = 1'b1;
        @(negedge CLK);
        start_a = 1'b0;
        start_b = 1'b0;
        foreach (stim_bytes[k]) send_byte(sel, stim_bytes[k], gaps);
`ifdef ROM_LOADER_CHECKSUM_EN
        send_byte(sel, csum[15:8], gaps);
        send_byte(sel, csum[7:0], gaps);
`endif
        byte_valid = 1'b0;
        guard = 0;
        while ((sel ? done_b : done_a) == 0) begin
            @(negedge CLK);
            guard++;
            if (guard > 50) timeout_fail("done wait");
        end
        repeat (2) @(negedge CLK);
    endtask

    task automatic check_load(input bit sel, input bit gaps, input bit detailed, input string name);
        wr_t  q[$];
        int   dn;
        int   dcyc;
        logic cerr;
        logic bsy;
        int   errs;
        errs = 0;
        if (sel) begin
            q = wr_b; dn = done_b; dcyc = done_cyc_b; cerr = csum_done_b; bsy = b_busy;
        end else begin
            q = wr_a; dn = done_a; dcyc = done_cyc_a; cerr = csum_done_a; bsy = a_busy;
        end
        check_output($sformatf("%s write count", name), 64'(q.size()), 64'(exp_words.size()));
        for (int i = 0; i < q.size() && i < exp_words.size(); i++) begin
            if (detailed) begin
                check_output($sformatf("%s addr[%0d]", name, i), 64'(q[i].addr), 64'(i));
                check_output($sformatf("%s data[%0d]", name, i), 64'(q[i].data), 64'(exp_words[i]));
                if (!gaps && i > 0)
                    check_output($sformatf("%s spacing[%0d]", name, i),
                                 64'(q[i].cyc - q[i-1].cyc), 64'd3);
            end else if (q[i].addr != 11'(i) || q[i].data != exp_words[i] ||
                         (!gaps && i > 0 && q[i].cyc - q[i-1].cyc != 3)) begin
                errs++;
            end
        end
        if (!detailed) check_output($sformatf("%s order errors", name), 64'(errs), 64'd0);
        check_output($sformatf("%s done pulses", name), 64'(dn), 64'd1);
`ifndef ROM_LOADER_CHECKSUM_EN
        if (q.size() > 0)
            check_output($sformatf("%s done timing", name), 64'(dcyc), 64'(q[q.size()-1].cyc + 1));
`endif
        check_output($sformatf("%s csum_err at done", name), 64'(cerr), 64'd0);
        check_output($sformatf("%s busy after", name), 64'(bsy), 64'd0);
    endtask

    initial begin
        // Table of 4-word loads: input stream, gap mode, expected words.
        vecs[0].stream = 64'h1234_5678_9ABC_DEF0; vecs[0].gaps = 1'b0;
        vecs[0].exp    = {16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
        vecs[1].stream = 64'h1234_5678_9ABC_DEF0; vecs[1].gaps = 1'b1;
        vecs[1].exp    = {16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
        vecs[2].stream = 64'hFFFF_0000_8001_7FFE; vecs[2].gaps = 1'b0;
        vecs[2].exp    = {16'hFFFF, 16'h0000, 16'h8001, 16'h7FFE};
        vecs[3].stream = 64'h0001_FFFF_0000_0000; vecs[3].gaps = 1'b1;
        vecs[3].exp    = {16'h0001, 16'hFFFF, 16'h0000, 16'h0000};
        for (int v = 4; v < 6; v++) begin
            vecs[v].stream = {32'($urandom), 32'($urandom)};
            vecs[v].gaps   = 1'b1;
            for (int i = 0; i < 4; i++) vecs[v].exp[i] = model_word(vecs[v].stream, i);
        end

        // Reset state with RST_N held low.
        #12;
        check_output("reset a ctl", {a_byte_ready, a_mode, a_busy, a_done, a_csum_err}, 64'd0);
        check_output("reset a addr/data", {a_column_id, a_wdata}, 64'd0);
        check_output("reset b ctl", {b_byte_ready, b_mode, b_busy, b_done, b_csum_err}, 64'd0);
        check_output("reset b addr/data", {b_column_id, b_wdata}, 64'd0);

        @(negedge CLK);
        RST_N = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            check_output($sformatf("idle cycle %0d", c),
                         {a_byte_ready, a_mode, b_byte_ready, b_mode}, 64'd0);
        end

        // Table-driven 4-word loads.
        for (int v = 0; v < 6; v++) begin
            clear_monitor();
            stim_bytes.delete();
            exp_words.delete();
            for (int k = 0; k < 8; k++) stim_bytes.push_back(vecs[v].stream[63-8*k -: 8]);
            for (int i = 0; i < 4; i++) exp_words.push_back(vecs[v].exp[i]);
            apply_stimulus(1'b0, vecs[v].gaps, model_sum());
            check_load(1'b0, vecs[v].gaps, 1'b1, $sformatf("vec%0d", v));
        end

        // Abort after the high byte of word 2, with a low byte offered in
        // the same cycle as the abort.
        clear_monitor();
        start_a = 1'b1;
        @(negedge CLK);
        start_a = 1'b0;
        send_byte(1'b0, 8'h11, 1'b0);
        send_byte(1'b0, 8'h11, 1'b0);
        send_byte(1'b0, 8'h22, 1'b0);
        send_byte(1'b0, 8'h22, 1'b0);
        send_byte(1'b0, 8'h33, 1'b0);
        abort      = 1'b1;
        byte_valid = 1'b1;
        byte_in    = 8'h44;
        @(negedge CLK);
        abort      = 1'b0;
        byte_valid = 1'b0;
        check_output("abort next cycle", {a_busy, a_byte_ready, a_mode}, 64'd0);
        repeat (5) @(negedge CLK);
        check_output("abort write count", 64'(wr_a.size()), 64'd2);
        check_output("abort no done", 64'(done_a), 64'd0);
        if (wr_a.size() == 2)
            check_output("abort kept writes", {wr_a[0].addr, wr_a[1].addr, wr_a[1].data},
                         {11'd0, 11'd1, 16'h2222});

        // Restart after abort begins again at address 0.
        clear_monitor();
        stim_bytes = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6, 8'h07, 8'h18};
        exp_words  = '{16'hA1B2, 16'hC3D4, 16'hE5F6, 16'h0718};
        apply_stimulus(1'b0, 1'b0, model_sum());
        check_load(1'b0, 1'b0, 1'b1, "restart");

        // start together with abort in IDLE: abort wins.
        start_a = 1'b1;
        abort   = 1'b1;
        @(negedge CLK);
        start_a = 1'b0;
        abort   = 1'b0;
        check_output("start+abort idle", {a_busy, a_byte_ready}, 64'd0);

        // Asynchronous reset during a WRITE cycle.
        start_a = 1'b1;
        @(negedge CLK);
        start_a = 1'b0;
        send_byte(1'b0, 8'h5A, 1'b0);
        send_byte(1'b0, 8'hC3, 1'b0);
        byte_valid = 1'b0;
        check_output("pre-reset write", {a_mode, a_wdata}, {2'b01, 16'h5AC3});
        #2 RST_N = 1'b0;
        #1;
        check_output("async reset ctl", {a_mode, a_busy, a_byte_ready, a_done}, 64'd0);
        check_output("async reset addr/data", {a_column_id, a_wdata}, 64'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (2) @(negedge CLK);

        // Full 2048-word fill with word value equal to its address.
        clear_monitor();
        stim_bytes.delete();
        exp_words.delete();
        for (int i = 0; i < 2048; i++) begin
            stim_bytes.push_back(8'(i / 256));
            stim_bytes.push_back(8'(i % 256));
            exp_words.push_back(16'(i));
        end
        apply_stimulus(1'b1, 1'b0, model_sum());
        check_load(1'b1, 1'b0, 1'b0, "full fill");
        if (wr_b.size() > 0)
            check_output("full fill last write",
                         {wr_b[wr_b.size()-1].addr, wr_b[wr_b.size()-1].data},
                         {11'h7FF, 16'h07FF});
        begin
            int zero_writes = 0;
            foreach (wr_b[i]) if (wr_b[i].addr == 11'd0) zero_writes++;
            check_output("full fill addr0 writes", 64'(zero_writes), 64'd1);
        end

`ifdef ROM_LOADER_CHECKSUM_EN
        // Words 0x0001 and 0xFFFF sum to 0x0000.
        stim_bytes = '{8'h00, 8'h01, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
        exp_words  = '{16'h0001, 16'hFFFF, 16'h0000, 16'h0000};
        clear_monitor();
        apply_stimulus(1'b0, 1'b0, 16'h0000);
        check_output("csum match", 64'(csum_done_a), 64'd0);
        clear_monitor();
        apply_stimulus(1'b0, 1'b0, 16'h0001);
        check_output("csum mismatch at done", 64'(csum_done_a), 64'd1);
        check_output("csum mismatch held", 64'(a_csum_err), 64'd1);
        check_output("csum writes only data", 64'(wr_a.size()), 64'd4);
        clear_monitor();
        apply_stimulus(1'b0, 1'b1, model_sum());
        check_output("csum cleared by start", 64'(csum_done_a), 64'd0);
`endif

        check_output("mode always 00/01", 64'(illegal_mode), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rom_loader.md
# rom_loader

Program loader that sits directly upstream of the 16-bank instruction ROM array. It accepts a byte stream over a valid/ready handshake, assembles big-endian 16-bit words, and drives the ROM's write-side inputs: word address `column_id`, write data and write `mode`. One word is written per ROM-addressed location, incrementing from address 0. It fills the ROM after reset or on host command, before the CPU starts fetching.

## Interface
Parameters:
- `LOAD_WORDS`, default 2048: words written per load, legal range 1..2048.

Ports:
- `CLK`  in  1  single clock; all logic is rising-edge.
- `RST_N`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle load request; ignored while `busy`.
- `abort`  in  1  synchronous cancel of a load in progress.
- `byte_in`  in  8  stream data.
- `byte_valid`  in  1  `byte_in` is valid.
- `byte_ready`  out  1  loader accepts a byte this cycle.
- `column_id`  out  11  ROM word address; [10:7] selects the bank, [6:0] the word within it.
- `wdata`  out  16  word to the ROM `in` port.
- `mode`  out  2  ROM mode: 2'b01 writes the selected bank, 2'b00 means no write.
- `busy`  out  1  a load is in progress.
- `done`  out  1  one-cycle pulse when a load completes.
- `csum_err`  out  1  checksum mismatch flag (see Configuration).

## Operation
- States: IDLE, HI, LO, WRITE, DONE. With checksum compiled in, add CHI and CLO.
- IDLE:
  - On `start`, clear the address counter to 0 and go to HI.
  - Clear `csum_err` and the checksum accumulator.
- HI: `byte_ready`=1. On accept (`byte_valid & byte_ready`), latch `wdata[15:8]` and go to LO.
- LO: `byte_ready`=1. On accept, latch `wdata[7:0]` and go to WRITE.
- WRITE:
  - `mode`=2'b01 for exactly one cycle; `column_id` = counter, `wdata` = assembled word.
  - If counter == `LOAD_WORDS`-1, go to DONE (or CHI with checksum); otherwise increment the counter and go to HI.
- DONE: `done`=1 for one cycle, then IDLE.
- `busy`=1 in every state except IDLE.
- Byte transfer:
  - A byte transfers only when both `byte_valid` and `byte_ready` are high.
  - `byte_valid` with `byte_ready` low is not consumed; the producer holds it.
- Address arithmetic:
  - The counter is 11-bit and never wraps within a load.
  - `LOAD_WORDS`=2048 ends at address 2047 (bank 15, word 127).
- `abort`:
  - In any non-IDLE state, go to IDLE on the next edge with `mode`=00.
  - No `done` pulse; ROM words already written stay written.
  - `abort` wins over a simultaneous byte accept or WRITE.
- `start` and `abort` together in IDLE: `abort` wins and the loader stays IDLE.

## Timing
- Reset values: `column_id`=0, `wdata`=0, `mode`=2'b00, `byte_ready`=0, `busy`=0, `done`=0, `csum_err`=0, state IDLE.
- `RST_N` low mid-load forces the reset values immediately and asynchronously; any in-flight WRITE cycle is dropped.
- `start` sampled at edge N gives `busy`=1 and `byte_ready`=1 from edge N onward.
- Low byte accepted at edge N: WRITE (`mode`=01) occupies cycle N..N+1, and the ROM captures the word at edge N+1.
- `column_id` and `wdata` are stable throughout the write cycle.
- Maximum throughput is 3 cycles per word with `byte_valid` held high.
- `done` rises the cycle after the last WRITE; with checksum, the cycle after the CLO accept.
- `mode` is 2'b00 in all cycles other than WRITE.

## Configuration
- Macro: `ROM_LOADER_CHECKSUM_EN`.
- Defined:
  - Every written word is added to a 16-bit accumulator, modulo 2^16.
  - After the last WRITE, CHI and CLO accept two more bytes (high byte first) as the expected sum.
  - `csum_err` is set in the DONE cycle if the sum differs, and held until the next `start` or reset.
  - The checksum bytes are never written to ROM.
- Undefined: no accumulator and no CHI/CLO; WRITE goes straight to DONE; `csum_err` is tied to 0.

## Test plan
- Reset then idle: with `RST_N` low, all outputs are 0. After release with no `start`, `byte_ready` stays 0 and `mode` stays 00 for 20 cycles.
- `LOAD_WORDS`=4, bytes 12 34 56 78 9A BC DE F0 with valid always high:
  - Writes 0x1234@0, 0x5678@1, 0x9ABC@2 and 0xDEF0@3, each with `mode`=01 for one cycle, 3 cycles apart.
  - `done` pulses once, then `busy`=0.
- Backpressure and gaps: `byte_valid` toggles randomly; all words are still written exactly once, in order, with no extra `mode`=01 cycles.
- Full fill, `LOAD_WORDS`=2048, word value = address: the last write is at `column_id`=0x7FF with `wdata`=0x07FF, and no write ever goes to address 0 after the first.
- Abort after the high byte of word 2: the next cycle is IDLE with `mode`=00 and no `done`. A new `start` restarts at address 0.
- With `ROM_LOADER_CHECKSUM_EN` and words 0x0001 and 0xFFFF:
  - Trailing bytes 00 00 give `csum_err`=0.
  - Trailing bytes 00 01 give `csum_err`=1 in the `done` cycle.
